// File: rtl/count_enable_gen.sv
// Purpose: one-cycle count enable from a free-running rate divider and/or a debounced pushbutton.
// Latency: En registered; key pulse lands DB_CYCLES+3 edges after Key_n first samples low.
// Backpressure: none; the downstream counter consumes every En pulse unconditionally.
module count_enable_gen #(
    parameter int DIV       = 50000000,
    parameter int DIV_W     = 26,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Mode,
    input  logic             Run,
    input  logic             Key_n,
    output logic             En,
    output logic             Key_level,
    output logic [DIV_W-1:0] Phase
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  CNT_LAST   = DB_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             ks_q, ks_d;
    db_state_t        state_q, state_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             key_level_q, key_level_d;
    logic             mode_prev_q, mode_prev_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic             en_q, en_d;
    logic             key_pulse;
    logic             auto_pulse;

    // Mode is captured during reset so leaving reset is not mistaken for a mode change.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            sync1_q     <= 1'b1;
            ks_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level_q <= 1'b0;
            mode_prev_q <= Mode;
            phase_q     <= '0;
            en_q        <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            ks_q        <= ks_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level_q <= key_level_d;
            mode_prev_q <= mode_prev_d;
            phase_q     <= phase_d;
            en_q        <= en_d;
        end
    end

    always_comb begin
        sync1_d = Key_n;
        ks_d    = sync1_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ks_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (ks_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    key_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (ks_q) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!ks_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Stability window restarts on every state change.
        if (state_d != state_q) cnt_d = '0;
        key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_comb begin
        mode_prev_d = Mode;
        phase_d     = phase_q;
        auto_pulse  = 1'b0;
        if (Mode != mode_prev_q) begin
            phase_d = '0;
        end else if (!Mode) begin
            phase_d = '0;
        end else if (Run) begin
            if (phase_q == PHASE_LAST) begin
                phase_d    = '0;
                auto_pulse = 1'b1;
            end else begin
                phase_d = phase_q + DIV_W'(1);
            end
        end
        en_d = key_pulse | auto_pulse;
    end

    assign En        = en_q;
    assign Key_level = key_level_q;
    assign Phase     = phase_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: expectations are queued per cycle while stimulus is driven
// and popped/compared by a monitor on the falling clock edge.
module tb_count_enable_gen;

    localparam int DIV       = 5;
    localparam int DIV_W     = 3;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 2;

    localparam int K_EN = 0;
    localparam int K_KL = 1;
    localparam int K_PH = 2;

    logic             clk;
    logic             clr;
    logic             mode;
    logic             run;
    logic             key_n;
    logic             en;
    logic             key_level;
    logic [DIV_W-1:0] phase;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_vec;
    int   n_bad;

    count_enable_gen #(
        .DIV       (DIV),
        .DIV_W     (DIV_W),
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) dut (
        .Clk       (clk),
        .Clr       (clr),
        .Mode      (mode),
        .Run       (run),
        .Key_n     (key_n),
        .En        (en),
        .Key_level (key_level),
        .Phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int at, input int kind, input logic [31:0] val);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        clr = 1'b0;
        repeat (n) tick();
        clr = 1'b1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.at < cyc)
                chk("stale_expectation", 32'(cyc), 32'(e.at));
            else if (e.kind == K_EN)
                chk("En", 32'(en), e.val);
            else if (e.kind == K_KL)
                chk("Key_level", 32'(key_level), e.val);
            else
                chk("Phase", 32'(phase), e.val);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int ph;
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        clr   = 1'b0;
        mode  = 1'b1;
        run   = 1'b1;
        key_n = 1'b1;

        // Reset values, then free-running divider with a pulse on each wrap.
        do_reset(2);
        c0 = cyc;
        push(c0, K_EN, 0);
        push(c0, K_KL, 0);
        push(c0, K_PH, 0);
        for (int k = 1; k <= 15; k++) begin
            push(c0 + k, K_PH, 32'(k % 5));
            push(c0 + k, K_EN, 32'(k % 5 == 0));
        end
        repeat (15) tick();

        // Clean press held 20 cycles in step mode, then release.
        mode = 1'b0;
        do_reset(2);
        c0 = cyc;
        key_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            push(c0 + k, K_EN, 32'(k == 7));
            push(c0 + k, K_KL, 32'(k >= 7));
            push(c0 + k, K_PH, 0);
        end
        repeat (20) tick();
        c1 = cyc;
        key_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push(c1 + k, K_EN, 0);
            push(c1 + k, K_KL, 32'(k < 7));
        end
        repeat (10) tick();

        // Bouncy press: 0,1,0,1,0 then steady low from the fifth edge.
        do_reset(2);
        c0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            push(c0 + k, K_EN, 32'(k == 11));
            push(c0 + k, K_KL, 32'(k >= 11));
        end
        for (int j = 1; j <= 20; j++) begin
            key_n = (j == 2 || j == 4) ? 1'b1 : 1'b0;
            tick();
        end
        key_n = 1'b1;

        // Pause at Phase=2, resume, then Mode 1->0->1 clears Phase.
        mode = 1'b1;
        do_reset(2);
        c0 = cyc;
        for (int k = 1; k <= 21; k++) begin
            if (k <= 2)       ph = k;
            else if (k <= 12) ph = 2;
            else if (k <= 14) ph = k - 10;
            else if (k == 15) ph = 0;
            else if (k == 16) ph = 1;
            else if (k <= 19) ph = 0;
            else              ph = k - 19;
            push(c0 + k, K_PH, 32'(ph));
            push(c0 + k, K_EN, 32'(k == 15));
        end
        repeat (2) tick();
        run = 1'b0;
        repeat (10) tick();
        run = 1'b1;
        repeat (4) tick();
        mode = 1'b0;
        repeat (2) tick();
        mode = 1'b1;
        repeat (3) tick();

        // Key pulse and divider wrap on the same edge give one single-cycle En.
        do_reset(2);
        c0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            push(c0 + k, K_EN, 32'(k % 5 == 0));
            push(c0 + k, K_KL, 32'(k >= 10));
            push(c0 + k, K_PH, 32'(k % 5));
        end
        repeat (3) tick();
        key_n = 1'b0;
        repeat (17) tick();
        key_n = 1'b1;

        // Reset during PRESS_WAIT aborts the press; a later press works normally.
        mode = 1'b0;
        do_reset(2);
        c0 = cyc;
        key_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            push(c0 + k, K_EN, 32'(k == 21));
            push(c0 + k, K_KL, 32'(k >= 21));
        end
        repeat (5) tick();
        key_n = 1'b1;
        clr   = 1'b0;
        tick();
        clr   = 1'b1;
        repeat (8) tick();
        key_n = 1'b0;
        repeat (16) tick();
        key_n = 1'b1;

        repeat (2) tick();
        chk("pending_expectations", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/count_enable_gen.md
Name: count_enable_gen

Overview:
Upstream stage for the T-flip-flop counters. It produces the single-cycle enable pulse that drives the counter's En input, so the counter advances once per pulse instead of once per clock edge. There are two pulse sources. Auto mode uses a programmable rate divider, for example 1 Hz from 50 MHz. Step mode uses a debounced, edge-detected pushbutton. The block lets the board counters run at a visible rate or be single-stepped from a KEY.

Parameters:
DIV, 50000000, clock cycles per auto-mode pulse (must be ≥2)
DIV_W, 26, width of divider phase counter (2^DIV_W ≥ DIV)
DB_CYCLES, 1000000, cycles the synchronized key must stay stable to be accepted (must be ≥2)
DB_W, 20, width of debounce counter (2^DB_W ≥ DB_CYCLES)

Ports:
Clk  in  1  system clock; all state updates on rising edge
Clr  in  1  reset, synchronous, active-low; Clr=0 at a rising edge resets all state
Mode  in  1  0 = step (key) only, 1 = auto (divider) plus key
Run  in  1  auto-mode gate; 0 pauses the divider
Key_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
En  out  1  registered one-cycle enable pulse to the counter
Key_level  out  1  debounced key state, 1 = pressed
Phase  out  DIV_W  current divider phase (debug/bench visibility)

Behaviour:
- Reset (Clr=0 at an edge):
  - En=0, Key_level=0, Phase=0.
  - Debounce counter=0, FSM=IDLE.
  - Both synchronizer flops=1 (released).
  - A press in progress is aborted with no pulse.
- Synchronizer: two flops on Key_n. The FSM sees the second flop, ks. This gives 2 cycles of latency.
- Debounce FSM (DB counter cleared on every state change):
  - IDLE: ks=0 -> PRESS_WAIT.
  - PRESS_WAIT:
    - ks=1 -> IDLE (bounce rejected).
    - ks=0 and cnt==DB_CYCLES-1 -> PRESSED and assert key pulse.
    - Otherwise cnt++.
  - PRESSED: ks=1 -> RELEASE_WAIT.
  - RELEASE_WAIT:
    - ks=0 -> PRESSED.
    - ks=1 and cnt==DB_CYCLES-1 -> IDLE.
    - Otherwise cnt++.
  - Key_level=1 in PRESSED and RELEASE_WAIT, 0 otherwise (registered with the state).
  - Release never generates a pulse. Exactly one key pulse per accepted press, regardless of hold time.
- Key latency: counting the first edge that samples Key_n=0 as edge 1, with Key_n held low, En is high for exactly the cycle after edge DB_CYCLES+3.
- Divider:
  - Mode=1 and Run=1: Phase increments each cycle. At Phase==DIV-1 it wraps to 0 and an auto pulse is asserted on that same edge, so En is high while Phase==0 after the wrap.
  - Period is exactly DIV cycles. The first pulse follows the DIV-th enabled edge after Phase=0.
  - Run=0 (Mode=1): Phase holds its value, no auto pulses. Resuming continues from the held value.
  - Mode=0: Phase forced to 0, no auto pulses.
  - Any change of Mode clears Phase to 0 on that edge.
- En = registered OR of the key pulse and the auto pulse. When both occur on the same edge, En is a single one-cycle pulse (no double count, no stretching). En never stays high two consecutive cycles unless independent events fall on consecutive edges.
- Key pulses are honoured in both modes. Run does not gate the key.
- No combinational path from any input to any output.

Test Plan:
Use DIV=5, DB_CYCLES=4, Key_n=1, Mode=1, Run=1 unless stated.
1. Reset: Clr=0 for 2 edges -> En=0, Key_level=0, Phase=0. Release Clr -> Phase counts 1,2,3,4,0. En=1 only in the cycle with Phase=0 after the wrap, then repeats every 5 cycles.
2. Clean press (Mode=0): Key_n=0 from edge 1, held 20 cycles -> En=1 for the single cycle after edge 7. Key_level=1 from the same edge. No further pulse while held. Release -> Key_level=0 after 7 edges, no En.
3. Bounce (Mode=0): Key_n pattern 0,1,0,1,0 then steady 0 -> bounces rejected. Exactly one En pulse, 7 edges after the start of steady low.
4. Pause/mode: Run=0 at Phase=2 for 10 cycles -> Phase stays 2, En=0. Run=1 -> pulse 3 cycles later. Toggle Mode 1->0->1 -> Phase=0 after each change.
5. Coincidence: time an accepted press so the key pulse and the divider wrap fall on the same edge -> En high exactly one cycle.
6. Reset mid-operation: Clr=0 while in PRESS_WAIT at cnt=2 -> no En, FSM=IDLE. A later clean press yields a normal single pulse.
